alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins a simultaneous request.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 req0_opA, req0_opB, req1_opA, req1_opB  input  16 each  operands.
REQ-007 req0_sel, req1_sel  input  2 each  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-008 alu_opA, alu_opB  output  16 each  operands driven to the shared 16-bit ALU.
REQ-009 alu_sel  output  2  operation select driven to the ALU.
REQ-010 alu_res  input  16  ALU result, combinational from alu_opA/alu_opB/alu_sel.
REQ-011 alu_flag_c, alu_flag_z, alu_flag_o  input  1 each  ALU carry, zero and overflow flags.
REQ-012 rsp_valid  output  1  a response is held on the rsp_* outputs.
REQ-013 rsp_ready  input  1  consumer takes the response.
REQ-014 rsp_id  output  1  requester that owns the response.
REQ-015 rsp_res  output  16  captured ALU result.
REQ-016 rsp_flag_c, rsp_flag_z, rsp_flag_o  output  1 each  captured ALU flags.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-019 In IDLE, the arbiter SHALL assert exactly one reqN_ready, combinationally, for the granted requester whose reqN_valid is high; with no valid request, both readies SHALL be 0.
REQ-020 Grant rule: with one request valid, that requester SHALL be granted; with both valid and FIXED_PRIO=0, the requester not granted last SHALL win; with FIXED_PRIO=1, requester 0 SHALL win.
REQ-021 On accept (reqN_valid & reqN_ready), the block SHALL register the opA, opB and sel of the granted requester onto alu_opA/alu_opB/alu_sel, record N as owner and last-grant, and move to EXEC.
REQ-022 In EXEC, which lasts exactly one cycle, the block SHALL capture alu_res and all three alu_flag_* into the rsp_* registers at the end of the cycle and move to RESP.
REQ-023 In RESP, rsp_valid SHALL be 1, and rsp_id, rsp_res and rsp_flag_* SHALL hold stable until rsp_valid & rsp_ready.
REQ-024 On that handshake the FSM SHALL return to IDLE, and rsp_valid SHALL fall the next cycle.
REQ-025 Latency SHALL be 2 cycles from the accept edge to rsp_valid=1; throughput SHALL be at most one operation per 3 cycles.
REQ-026 Both reqN_ready outputs SHALL be 0 in EXEC and RESP; requests arriving then SHALL wait, with no loss or reorder.
REQ-027 alu_opA/alu_opB/alu_sel SHALL hold their last accepted values outside EXEC.
REQ-028 The block SHALL NOT modify ALU data or flags; widths SHALL be 16 bits throughout.
REQ-029 A requester deasserting valid while not granted SHALL have no effect; valid without ready SHALL NOT be accepted.

Reset
REQ-030 While rst_n=0, the block SHALL immediately, without waiting for clk, set the FSM to IDLE and the last-grant pointer to 1 (requester 0 wins the first tie).
REQ-031 While rst_n=0, all outputs SHALL be 0: alu_opA, alu_opB, alu_sel, rsp_valid, rsp_id, rsp_res, rsp_flag_*, busy and both readies.
REQ-032 Reset asserted in EXEC or RESP SHALL discard the in-flight operation, and no response for it SHALL appear after release.
REQ-033 After rst_n rises, the first accept SHALL be possible on the first rising clk edge.

Verification
REQ-034 req0 ADD 15+15, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_res=30, c=z=o=0.
REQ-035 Both valid after reset, FIXED_PRIO=0: req0 SUB 15-3, req1 OR 2000|3000 -> first response id=0, res=12; second id=1, res=4088; a following tie grants req0 again.
REQ-036 req1 ADD 32767+10 -> rsp_res=0x8009, flag_o=1, flag_c=0; req0 ADD 0x8000+0x8000 -> res=0, c=1, z=1, o=1.
REQ-037 rsp_ready held 0 for 4 cycles in RESP with req0_valid=1 -> rsp_* stable, req0_ready=0, busy=1 throughout; accept follows the cycle after the handshake.
REQ-038 rst_n pulsed low during EXEC of AND 0&0 -> all outputs 0 at once, no response after release; re-issue -> res=0, z=1.
REQ-039 FIXED_PRIO=1, both requesters continuously valid for 3 operations -> all three grants go to requester 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals between two requesters, the arbiter and a shared 16-bit ALU.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface alu_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_opA, req0_opB, req1_opA, req1_opB;
    logic [1:0]  req0_sel, req1_sel;
    logic [15:0] alu_opA, alu_opB;
    logic [1:0]  alu_sel;
    logic [15:0] alu_res;
    logic        alu_flag_c, alu_flag_z, alu_flag_o;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_res;
    logic        rsp_flag_c, rsp_flag_z, rsp_flag_o;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_opA, req0_opB, req1_opA, req1_opB, req0_sel, req1_sel,
        input  alu_res, alu_flag_c, alu_flag_z, alu_flag_o, rsp_ready,
        output req0_ready, req1_ready, alu_opA, alu_opB, alu_sel,
        output rsp_valid, rsp_id, rsp_res, rsp_flag_c, rsp_flag_z, rsp_flag_o, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_opA, req0_opB, req1_opA, req1_opB, req0_sel, req1_sel,
        output alu_res, alu_flag_c, alu_flag_z, alu_flag_o, rsp_ready,
        input  req0_ready, req1_ready, alu_opA, alu_opB, alu_sel,
        input  rsp_valid, rsp_id, rsp_res, rsp_flag_c, rsp_flag_z, rsp_flag_o, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and captures result plus flags.
// Response two cycles after accept; one operation in flight, readies held low until the response is taken.
module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_busy;
    logic [15:0] r_opa, r_opb, r_res;
    logic [1:0]  r_sel;
    logic        r_rsp_valid, r_rsp_id;
    logic        r_flag_c, r_flag_z, r_flag_o;
    logic        w_idle, w_gnt0, w_gnt1;

    // Readies are gated by rst_n so they drop the moment reset asserts, not at the next edge.
    assign w_idle = rst_n && (r_state == IDLE);
    assign w_gnt1 = w_idle && bus.req1_valid && (!bus.req0_valid || (!FIXED_PRIO && !r_last));
    assign w_gnt0 = w_idle && bus.req0_valid && !w_gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_busy      <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_sel       <= '0;
            r_res       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_o    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_opa   <= w_gnt1 ? bus.req1_opA : bus.req0_opA;
                        r_opb   <= w_gnt1 ? bus.req1_opB : bus.req0_opB;
                        r_sel   <= w_gnt1 ? bus.req1_sel : bus.req0_sel;
                        r_last  <= w_gnt1;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                // r_last doubles as the owner of the operation in flight.
                EXEC: begin
                    r_res       <= bus.alu_res;
                    r_flag_c    <= bus.alu_flag_c;
                    r_flag_z    <= bus.alu_flag_z;
                    r_flag_o    <= bus.alu_flag_o;
                    r_rsp_id    <= r_last;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.alu_opA    = r_opa;
    assign bus.alu_opB    = r_opb;
    assign bus.alu_sel    = r_sel;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_res    = r_res;
    assign bus.rsp_flag_c = r_flag_c;
    assign bus.rsp_flag_z = r_flag_z;
    assign bus.rsp_flag_o = r_flag_o;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic checked by a transaction-level model.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_arbiter_if b0 ();
    alu_arbiter_if bf ();

    alu_arbiter #(.FIXED_PRIO(1'b0)) dut    (.clk(clk), .rst_n(rst_n), .bus(b0));
    alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bf));

    // Reference ALU: {carry, zero, overflow, result}; SUB carry means borrow.
    function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        logic [16:0] w;
        logic        c, o;
        c = 1'b0;
        o = 1'b0;
        case (s)
            2'b00: begin
                w = {1'b0, a} + {1'b0, b};
                c = w[16];
                o = (a[15] == b[15]) && (w[15] != a[15]);
            end
            2'b01: begin
                w = {1'b0, a} - {1'b0, b};
                c = w[16];
                o = (a[15] != b[15]) && (w[15] != a[15]);
            end
            2'b10:   w = {1'b0, a & b};
            default: w = {1'b0, a | b};
        endcase
        return {c, (w[15:0] == 16'h0), o, w[15:0]};
    endfunction

    assign {b0.alu_flag_c, b0.alu_flag_z, b0.alu_flag_o, b0.alu_res} = alu_f(b0.alu_opA, b0.alu_opB, b0.alu_sel);
    assign {bf.alu_flag_c, bf.alu_flag_z, bf.alu_flag_o, bf.alu_res} = alu_f(bf.alu_opA, bf.alu_opB, bf.alu_sel);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ops"}, {b0.alu_opA, b0.alu_opB}, 32'h0);
        chk({tag, "_res"}, 32'(b0.rsp_res), 32'h0);
        chk({tag, "_ctl"}, 32'({b0.req0_ready, b0.req1_ready, b0.alu_sel, b0.rsp_valid, b0.rsp_id,
                                b0.rsp_flag_c, b0.rsp_flag_z, b0.rsp_flag_o, b0.busy}), 32'h0);
    endtask

    task automatic drive(input int n, input bit v, input logic [15:0] a, input logic [15:0] b, input logic [1:0] s);
        if (n == 0) begin
            b0.req0_valid = v; b0.req0_opA = a; b0.req0_opB = b; b0.req0_sel = s;
        end else begin
            b0.req1_valid = v; b0.req1_opA = a; b0.req1_opB = b; b0.req1_sel = s;
        end
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? b0.req0_ready : b0.req1_ready;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Entered at a falling edge; returns at a falling edge with the block idle again.
    task automatic op_direct(input int n, input logic [15:0] a, input logic [15:0] b, input logic [1:0] s,
                             input logic [15:0] res, input logic [2:0] czo);
        drive(n, 1'b1, a, b, s);
        b0.rsp_ready = 1'b1;
        #1 chk("d_accept", 32'(rdy(n)), 32'd1);
        @(negedge clk);
        drive(n, 1'b0, a, b, s);
        #1 chk("d_exec_busy", 32'(b0.busy), 32'd1);
        chk("d_exec_rv", 32'(b0.rsp_valid), 32'd0);
        @(negedge clk);
        #1 chk("d_rv", 32'(b0.rsp_valid), 32'd1);
        chk("d_id", 32'(b0.rsp_id), 32'(n));
        chk("d_res", 32'(b0.rsp_res), 32'(res));
        chk("d_czo", 32'({b0.rsp_flag_c, b0.rsp_flag_z, b0.rsp_flag_o}), 32'(czo));
        @(negedge clk);
    endtask

    // Entered at a falling edge; asserts reset mid-cycle, releases it at a later falling edge.
    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        #1 chk_zero("rst_now");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Transaction-level model of the FIXED_PRIO=0 instance, sampled every cycle.
    initial begin : monitor
        int          cyc, acc, g;
        bit          infl, last, rv, exp_id;
        logic [18:0] exp_r;
        logic [15:0] ha, hb;
        logic [1:0]  hs;
        cyc = 0; acc = 0; infl = 1'b0; last = 1'b1; exp_id = 1'b0;
        exp_r = '0; ha = '0; hb = '0; hs = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                chk_zero("m_rst");
                infl = 1'b0; last = 1'b1; ha = '0; hb = '0; hs = '0;
            end else begin
                g = -1;
                if (!infl) begin
                    if (b0.req0_valid && b0.req1_valid) g = last ? 0 : 1;
                    else if (b0.req0_valid)             g = 0;
                    else if (b0.req1_valid)             g = 1;
                end
                rv = infl && (cyc >= acc + 2);
                chk("m_rdy0", 32'(b0.req0_ready), 32'(g == 0));
                chk("m_rdy1", 32'(b0.req1_ready), 32'(g == 1));
                chk("m_busy", 32'(b0.busy), 32'(infl));
                chk("m_rv", 32'(b0.rsp_valid), 32'(rv));
                chk("m_alu", {b0.alu_opA, b0.alu_opB}, {ha, hb});
                chk("m_sel", 32'(b0.alu_sel), 32'(hs));
                if (rv) begin
                    chk("m_id", 32'(b0.rsp_id), 32'(exp_id));
                    chk("m_rsp", 32'({b0.rsp_flag_c, b0.rsp_flag_z, b0.rsp_flag_o, b0.rsp_res}), 32'(exp_r));
                end
                if (g == 0) begin
                    infl = 1'b1; acc = cyc; last = 1'b0; exp_id = 1'b0;
                    ha = b0.req0_opA; hb = b0.req0_opB; hs = b0.req0_sel;
                    exp_r = alu_f(ha, hb, hs);
                end else if (g == 1) begin
                    infl = 1'b1; acc = cyc; last = 1'b1; exp_id = 1'b1;
                    ha = b0.req1_opA; hb = b0.req1_opB; hs = b0.req1_sel;
                    exp_r = alu_f(ha, hb, hs);
                end else if (rv && b0.rsp_ready) begin
                    infl = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        bit have0, have1;
        int c0, c1;
        have0 = 1'b0; have1 = 1'b0;
        rst_n = 1'b0;
        drive(0, 1'b1, 16'h1234, 16'h5678, 2'b00);
        drive(1, 1'b1, 16'h1111, 16'h2222, 2'b01);
        b0.rsp_ready = 1'b0;
        bf.req0_valid = 1'b0; bf.req1_valid = 1'b0; bf.rsp_ready = 1'b0;
        bf.req0_opA = '0; bf.req0_opB = '0; bf.req0_sel = '0;
        bf.req1_opA = '0; bf.req1_opB = '0; bf.req1_sel = '0;
        #2 chk_zero("por");
        @(negedge clk);
        @(negedge clk);
        drive(1, 1'b0, 16'h0, 16'h0, 2'b00);
        rst_n = 1'b1;

        // Single ADD right after release: first edge accepts.
        op_direct(0, 16'd15, 16'd15, 2'b00, 16'd30, 3'b000);

        // Tie after reset: requester 0 first, then 1, then 0 wins the next tie.
        pulse_reset();
        drive(0, 1'b1, 16'd15, 16'd3, 2'b01);
        drive(1, 1'b1, 16'd2000, 16'd3000, 2'b11);
        b0.rsp_ready = 1'b1;
        #1 chk("tie_rdy0", 32'(b0.req0_ready), 32'd1);
        chk("tie_rdy1", 32'(b0.req1_ready), 32'd0);
        @(negedge clk);
        b0.req0_valid = 1'b0;
        #1 chk("tie_exec_rdy1", 32'(b0.req1_ready), 32'd0);
        @(negedge clk);
        #1 chk("tie_id0", 32'(b0.rsp_id), 32'd0);
        chk("tie_res0", 32'(b0.rsp_res), 32'd12);
        @(negedge clk);
        #1 chk("tie_rdy1_next", 32'(b0.req1_ready), 32'd1);
        @(negedge clk);
        b0.req1_valid = 1'b0;
        @(negedge clk);
        #1 chk("tie_id1", 32'(b0.rsp_id), 32'd1);
        chk("tie_res1", 32'(b0.rsp_res), 32'd4088);
        @(negedge clk);
        drive(0, 1'b1, 16'd1, 16'd1, 2'b00);
        drive(1, 1'b1, 16'd7, 16'd9, 2'b10);
        #1 chk("tie2_rdy0", 32'(b0.req0_ready), 32'd1);
        chk("tie2_rdy1", 32'(b0.req1_ready), 32'd0);
        @(negedge clk);
        b0.req0_valid = 1'b0;
        b0.req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Signed overflow and carry/zero corner cases.
        op_direct(1, 16'd32767, 16'd10, 2'b00, 16'h8009, 3'b001);
        op_direct(0, 16'h8000, 16'h8000, 2'b00, 16'h0000, 3'b111);

        // Response backpressure with a waiting requester.
        b0.rsp_ready = 1'b0;
        drive(0, 1'b1, 16'd100, 16'd23, 2'b00);
        #1 chk("bp_acc", 32'(b0.req0_ready), 32'd1);
        @(negedge clk);
        drive(0, 1'b1, 16'd500, 16'd1, 2'b01);
        #1 chk("bp_exec_rdy", 32'(b0.req0_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("bp_rv", 32'(b0.rsp_valid), 32'd1);
            chk("bp_res", 32'(b0.rsp_res), 32'd123);
            chk("bp_rdy", 32'(b0.req0_ready), 32'd0);
            chk("bp_busy", 32'(b0.busy), 32'd1);
        end
        @(negedge clk);
        b0.rsp_ready = 1'b1;
        #1 chk("bp_hs_rdy", 32'(b0.req0_ready), 32'd0);
        @(negedge clk);
        #1 chk("bp_reacc", 32'(b0.req0_ready), 32'd1);
        chk("bp_rv_fall", 32'(b0.rsp_valid), 32'd0);
        @(negedge clk);
        b0.req0_valid = 1'b0;
        @(negedge clk);
        #1 chk("bp_res2", 32'(b0.rsp_res), 32'd499);
        @(negedge clk);

        // Reset during EXEC discards the operation.
        drive(0, 1'b1, 16'h0, 16'h0, 2'b10);
        #1 chk("rx_acc", 32'(b0.req0_ready), 32'd1);
        @(negedge clk);
        b0.req0_valid = 1'b0;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("rx_no_rsp", 32'({b0.rsp_valid, b0.busy}), 32'd0);
        end
        @(negedge clk);
        op_direct(0, 16'h0, 16'h0, 2'b10, 16'h0, 3'b010);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (!have0 && $urandom_range(0, 2) == 0) begin
                have0 = 1'b1;
                b0.req0_opA = rnd16(); b0.req0_opB = rnd16(); b0.req0_sel = 2'($urandom_range(0, 3));
            end
            if (!have1 && $urandom_range(0, 2) == 0) begin
                have1 = 1'b1;
                b0.req1_opA = rnd16(); b0.req1_opB = rnd16(); b0.req1_sel = 2'($urandom_range(0, 3));
            end
            b0.req0_valid = have0 && ($urandom_range(0, 3) != 0);
            b0.req1_valid = have1 && ($urandom_range(0, 3) != 0);
            b0.rsp_ready  = ($urandom_range(0, 2) != 0);
            #1;
            if (b0.req0_valid && b0.req0_ready) have0 = 1'b0;
            if (b0.req1_valid && b0.req1_ready) have1 = 1'b0;
            if (i == 700) pulse_reset();
        end
        @(negedge clk);
        b0.req0_valid = 1'b0;
        b0.req1_valid = 1'b0;
        b0.rsp_ready  = 1'b1;
        repeat (4) @(negedge clk);

        // Fixed priority: requester 0 takes every grant while both stay valid.
        bf.req0_valid = 1'b1; bf.req0_opA = 16'd5; bf.req0_opB = 16'd6; bf.req0_sel = 2'b00;
        bf.req1_valid = 1'b1; bf.req1_opA = 16'd7; bf.req1_opB = 16'd8; bf.req1_sel = 2'b11;
        bf.rsp_ready  = 1'b1;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (bf.req0_ready) c0++;
            if (bf.req1_ready) c1++;
            if (bf.rsp_valid) begin
                chk("fp_id", 32'(bf.rsp_id), 32'd0);
                chk("fp_res", 32'(bf.rsp_res), 32'd11);
            end
            @(negedge clk);
        end
        chk("fp_grants0", 32'(c0), 32'd3);
        chk("fp_grants1", 32'(c1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
